// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered operands behind a valid/ready handshake, latency-1 logic/arith ops,
// and a WIDTH-cycle radix-2 Booth signed multiplier producing the full double-width product.
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_hi,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

    typedef enum logic [4:0] {
        OP_SUB  = 5'd0,
        OP_ADD  = 5'd1,
        OP_MUL  = 5'd2,
        OP_OR   = 5'd3,
        OP_AND  = 5'd4,
        OP_XOR  = 5'd5,
        OP_SLT  = 5'd6,
        OP_SLTU = 5'd7,
        OP_SLL  = 5'd8,
        OP_SRL  = 5'd9,
        OP_SRA  = 5'd10
    } op_e;

    localparam logic [SHW:0] CNT_DONE = (SHW+1)'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d, c_hi_q, c_hi_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qm1_q, qm1_d;
    logic [SHW:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0] alu_res, sum, diff;
    logic             alu_ovf, alu_err;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   m_ext, booth_sum;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SHW-1:0];

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        unique case (alu_op)
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            default: alu_err = 1'b1;
        endcase
    end

    // Accumulator is one bit wider than the operand so subtracting the most negative value cannot wrap.
    assign m_ext = {m_q[WIDTH-1], m_q};

    always_comb begin
        unique case ({lo_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        c_hi_d  = c_hi_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        m_d     = m_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (alu_op == OP_MUL) begin
                        m_d     = a;
                        acc_d   = '0;
                        lo_d    = b;
                        qm1_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        c_d     = alu_res;
                        c_hi_d  = '0;
                        zero_d  = (alu_res == '0);
                        ovf_d   = alu_ovf;
                        err_d   = alu_err;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_DONE) begin
                    c_d     = lo_q;
                    c_hi_d  = acc_q[WIDTH-1:0];
                    zero_d  = (lo_q == '0);
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
                    qm1_d = lo_q[0];
                    cnt_d = cnt_q + (SHW+1)'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            c_hi_q  <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            m_q     <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            c_hi_q  <= c_hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ready is gated by reset directly so it drops the moment rstn asserts.
    assign in_ready  = (state_q == S_IDLE) && rstn;
    assign out_valid = (state_q == S_DONE);
    assign c         = c_q;
    assign c_hi      = c_hi_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (WIDTH=32): handshake timing, arithmetic/flag results,
// backpressure, illegal op and asynchronous abort.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [4:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c, c_hi;
    logic        zero, ovf, err;

    int checks   = 0;
    int failures = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .c_hi      (c_hi),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge; caller is #1 after an edge with in_ready expected high.
    task automatic send(input logic [4:0] op, input logic [31:0] aa, input logic [31:0] bb);
        alu_op   = op;
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
        alu_op   = 5'd1;
    endtask

    // Edges after the accepting edge until out_valid is seen, bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] aa,
                          input logic [31:0] bb, input int exp_lat, input logic [31:0] exp_c,
                          input logic [31:0] exp_hi, input logic exp_z, input logic exp_ovf,
                          input logic exp_err);
        int lat;
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        send(op, aa, bb);
        wait_out(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_c"},   64'(c), 64'(exp_c));
        check({tag, "_chi"}, 64'(c_hi), 64'(exp_hi));
        check({tag, "_flags"}, 64'({zero, ovf, err}), 64'({exp_z, exp_ovf, exp_err}));
        take();
        check({tag, "_idle"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        int lat;
        rstn      = 1'b0;
        in_valid  = 1'b1;
        a         = 32'h1;
        b         = 32'h1;
        alu_op    = 5'd1;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready",  64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_c",         64'(c), 64'd0);
        check("rst_flags",     64'({c_hi, zero, ovf, err}), 64'd0);
        in_valid = 1'b0;
        rstn     = 1'b1;
        tick();
        check("rel_in_ready",  64'(in_ready), 64'd1);
        check("rel_out_valid", 64'(out_valid), 64'd0);

        //       tag     op     a             b             lat c             c_hi          z ov er
        run_op("add_ovf", 5'd1, 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 32'h0, 0, 1, 0);
        run_op("sub_zero", 5'd0, 32'd5,        32'd5,         0, 32'h0,         32'h0, 1, 0, 0);
        run_op("sub_ovf", 5'd0, 32'h8000_0000, 32'h0000_0001, 0, 32'h7FFF_FFFF, 32'h0, 0, 1, 0);
        run_op("add_neg", 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0, 0, 0, 0);
        run_op("mul_neg", 5'd2, 32'hFFFF_FFFD, 32'd7,        33, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 0, 0, 0);
        run_op("mul_hi",  5'd2, 32'h0001_0000, 32'h0001_0000, 33, 32'h0,        32'h1, 1, 0, 0);
        run_op("mul_min", 5'd2, 32'h8000_0000, 32'h8000_0000, 33, 32'h0,        32'h4000_0000, 1, 0, 0);
        run_op("mul_mix", 5'd2, 32'h8000_0000, 32'd3,        33, 32'h8000_0000, 32'hFFFF_FFFE, 0, 0, 0);
        run_op("or",      5'd3, 32'hF0F0_0000, 32'h0F0F_0001, 0, 32'hFFFF_0001, 32'h0, 0, 0, 0);
        run_op("and",     5'd4, 32'hF0F0_FFFF, 32'h0F0F_0000, 0, 32'h0,         32'h0, 1, 0, 0);
        run_op("xor",     5'd5, 32'hAAAA_5555, 32'hFFFF_0000, 0, 32'h5555_5555, 32'h0, 0, 0, 0);
        run_op("sra",     5'd10, 32'h8000_0000, 32'h21,      0, 32'hC000_0000, 32'h0, 0, 0, 0);
        run_op("srl",     5'd9, 32'h8000_0000, 32'h1F,        0, 32'h1,         32'h0, 0, 0, 0);
        run_op("sll",     5'd8, 32'h1,         32'hFFFF_FFFF, 0, 32'h8000_0000, 32'h0, 0, 0, 0);
        run_op("sltu",    5'd7, 32'h1,         32'hFFFF_FFFF, 0, 32'h1,         32'h0, 0, 0, 0);
        run_op("slt",     5'd6, 32'h1,         32'hFFFF_FFFF, 0, 32'h0,         32'h0, 1, 0, 0);
        run_op("slt_neg", 5'd6, 32'hFFFF_FFFF, 32'h1,         0, 32'h1,         32'h0, 0, 0, 0);
        run_op("illegal", 5'd31, 32'h1234,     32'h5678,      0, 32'h0,         32'h0, 1, 0, 1);
        run_op("illegal11", 5'd11, 32'h1,      32'h1,         0, 32'h0,         32'h0, 1, 0, 1);

        // Backpressure: result must hold while new requests are offered and ignored.
        send(5'd1, 32'd2, 32'd3);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            alu_op   = 5'd0;
            a        = 32'd100 + 32'(i);
            b        = 32'd1;
            tick();
            check("bp_c",     64'(c), 64'd5);
            check("bp_state", 64'({out_valid, in_ready}), 64'b10);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle", 64'({out_valid, in_ready}), 64'b01);
        tick();
        check("bp_no_capture", 64'(out_valid), 64'd0);

        // out_ready with nothing pending must not disturb the next op.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stray_ready", 64'({out_valid, in_ready}), 64'b01);

        // Abort mid-multiply: outputs clear while rstn is low, before any clock edge.
        send(5'd2, 32'h0000_1234, 32'h0000_5678);
        repeat (10) tick();
        rstn = 1'b0;
        #1;
        check("abort_mul_state", 64'({out_valid, in_ready}), 64'b00);
        check("abort_mul_out",   64'({c, c_hi, zero, ovf, err}), 64'd0);
        tick();
        rstn = 1'b1;
        tick();
        run_op("post_abort", 5'd1, 32'd1, 32'd1, 0, 32'd2, 32'h0, 0, 0, 0);

        // Abort while holding a result in DONE.
        send(5'd1, 32'h7FFF_FFFF, 32'h1);
        check("done_before_abort", 64'({out_valid, ovf}), 64'b11);
        rstn = 1'b0;
        #1;
        check("abort_done_valid", 64'(out_valid), 64'd0);
        check("abort_done_out",   64'({c, c_hi, zero, ovf, err}), 64'd0);
        tick();
        rstn = 1'b1;
        tick();
        send(5'd2, 32'd6, 32'd7);
        wait_out(lat);
        check("mul_after_abort_lat", 64'(lat), 64'd33);
        check("mul_after_abort_c",   64'({c_hi, c}), 64'd42);
        take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
